// File: rtl/video_timing_pkg.sv
// Shared raster definitions: FSM states, source-select codes and default geometry
// used by the stream generator and the filter blocks that consume its raster.
package video_timing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_V_PRE  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_V_POST = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  localparam logic [1:0] PAT_UPSTREAM = 2'd0;
  localparam logic [1:0] PAT_HRAMP    = 2'd1;
  localparam logic [1:0] PAT_VRAMP    = 2'd2;
  localparam logic [1:0] PAT_CONST    = 2'd3;

  localparam int Y16_DW           = 16;
  localparam int DEF_IMAGE_WIDTH  = 640;
  localparam int DEF_IMAGE_HEIGHT = 512;
  localparam int DEF_H_BLANK      = 64;
  localparam int DEF_V_PRE        = 2;
  localparam int DEF_V_POST       = 2;
  localparam int DEF_FRAME_GAP    = 16;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Column/row position counters for one field (pre-blank, active and post-blank rows).
// Held at zero while i_run is low so every field starts from column 0, row 0.
module video_timing_cnt
  import video_timing_pkg::*;
#(
  parameter int LINE_LEN = DEF_IMAGE_WIDTH + DEF_H_BLANK,
  parameter int ROWS     = DEF_V_PRE + DEF_IMAGE_HEIGHT + DEF_V_POST,
  parameter int H_W      = cnt_w(LINE_LEN),
  parameter int V_W      = cnt_w(ROWS)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_run,
  output logic [H_W-1:0] o_h_cnt,
  output logic [V_W-1:0] o_v_cnt,
  output logic           o_line_end,
  output logic           o_field_end
);

  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;

  assign o_line_end  = (r_h_cnt == H_W'(LINE_LEN - 1));
  assign o_field_end = o_line_end && (r_v_cnt == V_W'(ROWS - 1));
  assign o_h_cnt     = r_h_cnt;
  assign o_v_cnt     = r_v_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!i_run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (o_line_end) begin
      r_h_cnt <= '0;
      r_v_cnt <= o_field_end ? '0 : r_v_cnt + V_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + H_W'(1);
    end
  end

endmodule

// File: rtl/video_stream_gen.sv
// Raster source: field/line timing with blanking, pixels from upstream or a test pattern.
// Outputs are registered one cycle behind the counter position, so o_pix_rdy can look ahead.
//   state     | meaning
//   ST_IDLE   | stopped, all outputs low
//   ST_V_PRE  | field_vld high, blank rows before line 0
//   ST_ACTIVE | image rows: IMAGE_WIDTH pixels then H_BLANK idle per row
//   ST_V_POST | field_vld high, blank rows after the last line
//   ST_GAP    | field_vld low for FRAME_GAP cycles, then frame count
module video_stream_gen
  import video_timing_pkg::*;
#(
  parameter int DATA_W       = Y16_DW,
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int H_BLANK      = DEF_H_BLANK,
  parameter int V_PRE        = DEF_V_PRE,
  parameter int V_POST       = DEF_V_POST,
  parameter int FRAME_GAP    = DEF_FRAME_GAP
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [1:0]        i_pattern_sel,
  input  logic [DATA_W-1:0] i_const_val,
  input  logic              i_pix_vld,
  input  logic [DATA_W-1:0] i_pix_data,
  output logic              o_pix_rdy,
  input  logic              i_clr_err,
  output logic              o_field_vld,
  output logic              o_line_vld,
  output logic [DATA_W-1:0] o_img_data,
  output logic              o_underflow,
  output logic [15:0]       o_frame_cnt,
  output logic              o_busy
);

  localparam int LINE_LEN = IMAGE_WIDTH + H_BLANK;
  localparam int ROWS     = V_PRE + IMAGE_HEIGHT + V_POST;
  localparam int H_W      = cnt_w(LINE_LEN);
  localparam int V_W      = cnt_w(ROWS);
  localparam int GAP_W    = cnt_w(FRAME_GAP);

  localparam logic [V_W-1:0]   ROW_PRE_LAST  = V_W'(V_PRE - 1);
  localparam logic [V_W-1:0]   ROW_FIRST_ACT = V_W'(V_PRE);
  localparam logic [V_W-1:0]   ROW_ACT_LAST  = V_W'(V_PRE + IMAGE_HEIGHT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD      = GAP_W'(FRAME_GAP - 1);
  localparam state_t ST_FIRST     = (V_PRE > 0) ? ST_V_PRE : ST_ACTIVE;
  localparam state_t ST_AFTER_ACT = (V_POST > 0) ? ST_V_POST : ST_GAP;

  state_t             r_state, w_state_nxt;
  logic [H_W-1:0]     w_h_cnt;
  logic [V_W-1:0]     w_v_cnt;
  logic               w_line_end, w_field_end, w_run, w_field_start;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [1:0]         r_pat;
  logic [DATA_W-1:0]  r_const;
  logic               w_act_pix, w_underrun;
  logic [DATA_W-1:0]  w_pix;
  logic               r_field_vld, r_line_vld, r_underflow, r_busy;
  logic [DATA_W-1:0]  r_img_data;
  logic [15:0]        r_frame_cnt;

  assign w_run = (r_state == ST_V_PRE) || (r_state == ST_ACTIVE) || (r_state == ST_V_POST);

  video_timing_cnt #(
    .LINE_LEN (LINE_LEN),
    .ROWS     (ROWS),
    .H_W      (H_W),
    .V_W      (V_W)
  ) u_cnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_run       (w_run),
    .o_h_cnt     (w_h_cnt),
    .o_v_cnt     (w_v_cnt),
    .o_line_end  (w_line_end),
    .o_field_end (w_field_end)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_enable) w_state_nxt = ST_FIRST;
      ST_V_PRE:  if (w_line_end && (w_v_cnt == ROW_PRE_LAST)) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_line_end && (w_v_cnt == ROW_ACT_LAST)) w_state_nxt = ST_AFTER_ACT;
      ST_V_POST: if (w_field_end) w_state_nxt = ST_GAP;
      ST_GAP:    if (r_gap_cnt == '0) w_state_nxt = i_enable ? ST_FIRST : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Pixel position the registered outputs will show after the next edge.
  always_comb begin
    w_act_pix = (r_state == ST_ACTIVE) && (int'(w_h_cnt) < IMAGE_WIDTH);
    o_pix_rdy = w_act_pix && (r_pat == PAT_UPSTREAM);
    w_underrun = o_pix_rdy && !i_pix_vld;
    case (r_pat)
      PAT_HRAMP: w_pix = DATA_W'(w_h_cnt);
      PAT_VRAMP: w_pix = DATA_W'(w_v_cnt - ROW_FIRST_ACT);
      PAT_CONST: w_pix = r_const;
      default:   w_pix = i_pix_vld ? i_pix_data : ((w_h_cnt == '0) ? '0 : r_img_data);
    endcase
  end

  assign w_field_start = ((r_state == ST_IDLE) || (r_state == ST_GAP)) &&
                         ((w_state_nxt == ST_V_PRE) || (w_state_nxt == ST_ACTIVE));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gap_cnt   <= '0;
      r_pat       <= PAT_UPSTREAM;
      r_const     <= '0;
      r_frame_cnt <= '0;
      r_field_vld <= 1'b0;
      r_line_vld  <= 1'b0;
      r_img_data  <= '0;
      r_underflow <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_field_start) begin
        r_pat   <= i_pattern_sel;
        r_const <= i_const_val;
      end
      if ((w_state_nxt == ST_GAP) && (r_state != ST_GAP)) r_gap_cnt <= GAP_LOAD;
      else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      if ((r_state == ST_GAP) && (r_gap_cnt == '0)) r_frame_cnt <= r_frame_cnt + 16'd1;
      r_field_vld <= w_run;
      r_line_vld  <= w_act_pix;
      r_img_data  <= w_act_pix ? w_pix : '0;
      r_busy      <= (w_state_nxt != ST_IDLE);
      if (w_underrun)     r_underflow <= 1'b1;
      else if (i_clr_err) r_underflow <= 1'b0;
    end
  end

  assign o_field_vld = r_field_vld;
  assign o_line_vld  = r_line_vld;
  assign o_img_data  = r_img_data;
  assign o_underflow = r_underflow;
  assign o_frame_cnt = r_frame_cnt;
  assign o_busy      = r_busy;

endmodule
